// File: rtl/gaussian_pkg.sv
// Shared constants, pixel/coefficient types and FSM state encoding for the
// 5x5 Gaussian blur stage.
package gaussian_pkg;

   localparam int unsigned KSIZE     = 5;
   localparam int unsigned NTAPS     = KSIZE * KSIZE;
   localparam int unsigned COEF_FRAC = 16;
   localparam int unsigned ROUND_K   = 32768;

   typedef logic [15:0] coef_t;
   typedef logic [7:0]  pix_t;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain,
      StDone
   } blur_state_e;

endpackage

// File: rtl/gaussian_blur_stream_if.sv
// Pixel stream bundle: input handshake (valid/ready) and the unthrottled
// blurred output (valid only, no backpressure).
interface gaussian_blur_stream_if
   import gaussian_pkg::*;
#(
   parameter int unsigned PIX_W = 8
) ();

   logic [PIX_W-1:0] in_pix;
   logic             in_valid;
   logic             in_ready;
   logic [PIX_W-1:0] out_pix;
   logic             out_valid;

   modport slave (
      input  in_pix,
      input  in_valid,
      output in_ready,
      output out_pix,
      output out_valid
   );

   modport master (
      output in_pix,
      output in_valid,
      input  in_ready,
      input  out_pix,
      input  out_valid
   );

endinterface

// File: rtl/line_buffer.sv
// Single-row delay line: a shift register advanced only on accepted pixels.
// Contents are never cleared; callers gate consumption of stale data.
module line_buffer
   import gaussian_pkg::*;
#(
   parameter int unsigned DEPTH = 63,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         mem_q[0] <= din;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            mem_q[i] <= mem_q[i-1];
         end
      end
   end

   assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/gaussian_blur_stream.sv
// Streaming 5x5 Gaussian convolution: line-buffered window, 3-stage MAC
// pipeline (products, adder tree, round/saturate) and frame-control FSM.
module gaussian_blur_stream
   import gaussian_pkg::*;
#(
   parameter int unsigned IMG_WIDTH  = 64,
   parameter int unsigned IMG_HEIGHT = 64,
   parameter int unsigned PIX_W      = 8,
   parameter int unsigned COEF_W     = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [NTAPS*COEF_W-1:0] kernel_coef,
   gaussian_blur_stream_if.slave   stream,
   output logic                    busy,
   output logic                    done
);

   localparam int unsigned CNT_CW = $clog2(IMG_WIDTH);
   localparam int unsigned CNT_RW = $clog2(IMG_HEIGHT);
   localparam int unsigned PROD_W = PIX_W + COEF_W;
   localparam int unsigned SUM_W  = PROD_W + $clog2(NTAPS);
   localparam int unsigned QUO_W  = SUM_W + 1 - COEF_FRAC;

   blur_state_e state_q, state_d;

   logic [CNT_CW-1:0] col_q;
   logic [CNT_RW-1:0] row_q;
   logic [COEF_W-1:0] coef_q [NTAPS];
   logic [PIX_W-1:0]  win_q  [KSIZE][KSIZE];
   logic [PIX_W-1:0]  lb_out [KSIZE-1];
   logic [PROD_W-1:0] prod_q [NTAPS];
   logic [SUM_W-1:0]  sum_d, sum_q;
   logic [SUM_W:0]    rnd;
   logic [QUO_W-1:0]  quo;
   logic [PIX_W-1:0]  sat;
   logic [PIX_W-1:0]  out_pix_q;
   logic              launch_q, prod_v_q, sum_v_q, out_v_q;
   logic              accept, launch, last_pix, start_frame;

   assign start_frame = (state_q == StIdle) && start;
   assign accept      = (state_q == StRun) && stream.in_valid;
   assign launch      = accept && (row_q >= CNT_RW'(KSIZE-1)) && (col_q >= CNT_CW'(KSIZE-1));
   assign last_pix    = accept && (row_q == CNT_RW'(IMG_HEIGHT-1))
                               && (col_q == CNT_CW'(IMG_WIDTH-1));

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StRun;
         StRun:   if (last_pix) state_d = StDrain;
         // Last launch has left the product/sum stages once these clear.
         StDrain: if (!(launch_q || prod_v_q || sum_v_q)) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         col_q     <= '0;
         row_q     <= '0;
         launch_q  <= 1'b0;
         prod_v_q  <= 1'b0;
         sum_v_q   <= 1'b0;
         out_v_q   <= 1'b0;
         out_pix_q <= '0;
      end else begin
         state_q  <= state_d;
         launch_q <= launch;
         prod_v_q <= launch_q;
         sum_v_q  <= prod_v_q;
         out_v_q  <= sum_v_q;
         if (sum_v_q) out_pix_q <= sat;
         if (start_frame) begin
            col_q <= '0;
            row_q <= '0;
         end else if (accept) begin
            if (col_q == CNT_CW'(IMG_WIDTH-1)) begin
               col_q <= '0;
               row_q <= row_q + CNT_RW'(1);
            end else begin
               col_q <= col_q + CNT_CW'(1);
            end
         end
      end
   end

   // Datapath registers carry no reset; validity is tracked separately.
   always_ff @(posedge clk) begin
      if (start_frame && !reset) begin
         for (int unsigned k = 0; k < NTAPS; k++) begin
            coef_q[k] <= kernel_coef[k*COEF_W +: COEF_W];
         end
      end
      if (accept) begin
         for (int unsigned k = 0; k < KSIZE; k++) begin
            for (int unsigned j = KSIZE-1; j > 0; j--) begin
               win_q[k][j] <= win_q[k][j-1];
            end
         end
         win_q[0][0] <= stream.in_pix;
         for (int unsigned k = 1; k < KSIZE; k++) begin
            win_q[k][0] <= lb_out[k-1];
         end
      end
      // win_q[k][j] holds input (r-k, c-j); tap (i,j) uses input (r-4+i, c-4+j).
      for (int unsigned i = 0; i < KSIZE; i++) begin
         for (int unsigned j = 0; j < KSIZE; j++) begin
            prod_q[i*KSIZE+j] <= PROD_W'(win_q[KSIZE-1-i][KSIZE-1-j])
                               * PROD_W'(coef_q[i*KSIZE+j]);
         end
      end
      sum_q <= sum_d;
   end

   always_comb begin
      sum_d = '0;
      for (int unsigned k = 0; k < NTAPS; k++) begin
         sum_d = sum_d + SUM_W'(prod_q[k]);
      end
   end

   always_comb begin
      rnd = {1'b0, sum_q} + (SUM_W+1)'(ROUND_K);
      quo = rnd[SUM_W:COEF_FRAC];
      sat = (quo > QUO_W'({PIX_W{1'b1}})) ? '1 : quo[PIX_W-1:0];
   end

   for (genvar g = 0; g < KSIZE-1; g++) begin : g_lb
      line_buffer #(
         .DEPTH (IMG_WIDTH-1),
         .WIDTH (PIX_W)
      ) u_lb (
         .clk  (clk),
         .en   (accept),
         .din  (win_q[g][0]),
         .dout (lb_out[g])
      );
   end

   assign stream.in_ready  = (state_q == StRun);
   assign stream.out_pix   = out_pix_q;
   assign stream.out_valid = out_v_q;
   assign busy             = (state_q != StIdle);
   assign done             = (state_q == StDone);

endmodule

// File: tb/tb_gaussian_blur_stream.sv
// Scoreboard bench for gaussian_blur_stream: a direct 2-D convolution model
// fills the expected queue; a monitor checks pixel values and launch latency.
module tb_gaussian_blur_stream;
   import gaussian_pkg::*;

   localparam int W  = 16;
   localparam int H  = 16;
   localparam int OW = W - 4;
   localparam int OH = H - 4;
   localparam int N  = W * H;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [25*16-1:0] kernel_coef;
   logic             busy;
   logic             done;

   gaussian_blur_stream_if #(.PIX_W(8)) bus ();

   gaussian_blur_stream #(
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H),
      .PIX_W      (8),
      .COEF_W     (16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .kernel_coef (kernel_coef),
      .stream      (bus),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int acc_n = 0;
   int acc_base = 0;
   int out_n = 0;
   int out_base = 0;
   int done_cnt = 0;
   int last_out = -10;
   int img [H][W];
   int kc [25];
   int out_img [OH][OW];
   int exp_q [$];
   int lq [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Handshake observer: an accept seen here completes on the next rising edge.
   always @(negedge clk) begin
      if (!reset && bus.in_valid && bus.in_ready) begin
         if (((acc_n - acc_base) / W) >= 4 && ((acc_n - acc_base) % W) >= 4)
            lq.push_back(cyc + 1);
         acc_n++;
      end
   end

   always @(negedge clk) begin
      if (bus.out_valid) begin
         int oi;
         oi = out_n - out_base;
         if (exp_q.size() == 0) check("out_unexpected", 1, 0);
         else check("out_pix", int'(bus.out_pix), exp_q.pop_front());
         if (lq.size() == 0) check("launch_missing", 1, 0);
         else check("latency", cyc, lq.pop_front() + 3);
         if (oi >= 0 && oi < OH*OW) out_img[oi/OW][oi%OW] = int'(bus.out_pix);
         out_n++;
         last_out = cyc;
      end
      if (done) begin
         done_cnt++;
         check("done_after_last_out", cyc, last_out + 1);
         check("busy_in_done", int'(busy), 1);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   task automatic set_kernel();
      for (int k = 0; k < 25; k++) kernel_coef[k*16 +: 16] = 16'(kc[k]);
   endtask

   // Direct definition: out(y,x) = sum k[i][j]*in(y+i,x+j), rounded, clipped.
   task automatic build_expected();
      for (int y = 0; y < OH; y++) begin
         for (int x = 0; x < OW; x++) begin
            longint s;
            s = 0;
            for (int i = 0; i < 5; i++)
               for (int j = 0; j < 5; j++)
                  s += longint'(kc[i*5+j]) * longint'(img[y+i][x+j]);
            s = (s + 32768) / 65536;
            if (s > 255) s = 255;
            exp_q.push_back(int'(s));
         end
      end
   endtask

   function automatic int gauss_q(input int i, input int j);
      int a, b, t;
      a = (i > 2) ? i - 2 : 2 - i;
      b = (j > 2) ? j - 2 : 2 - j;
      if (a > b) begin t = a; a = b; b = t; end
      case ({a[1:0], b[1:0]})
         4'b0000: return 10430;
         4'b0001: return 6326;
         4'b0101: return 3837;
         4'b0010: return 1412;
         4'b0110: return 856;
         default: return 191;
      endcase
   endfunction

   // mode 0: continuous, 1: toggling 1-0, 2: random gaps. noise: start pulses
   // and kernel_coef scrambling while the frame runs.
   task automatic run_frame(input int mode, input bit noise, input int stop_at);
      int t, p, d0;
      build_expected();
      set_kernel();
      acc_base = acc_n;
      out_base = out_n;
      d0 = done_cnt;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      check("busy_after_start", int'(busy), 1);
      t = 0;
      p = 0;
      while (p < stop_at && t < 4000) begin
         bus.in_pix = 8'(img[p/W][p%W]);
         case (mode)
            0:       bus.in_valid = 1'b1;
            1:       bus.in_valid = (t % 2 == 0);
            default: bus.in_valid = ($urandom_range(0, 3) != 0);
         endcase
         if (noise) begin
            start = ($urandom_range(0, 7) == 0);
            for (int k = 0; k < 25; k++) kernel_coef[k*16 +: 16] = 16'($urandom);
         end
         @(posedge clk); #1;
         t++;
         p = acc_n - acc_base;
      end
      start = 1'b0;
      check("frame_pixels", p, stop_at);
      if (stop_at < N) return;
      bus.in_valid = 1'b0;
      t = 0;
      while (done_cnt == d0 && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      check("done_seen", done_cnt - d0, 1);
      repeat (4) @(posedge clk);
      #1;
      check("done_once", done_cnt - d0, 1);
      check("idle_busy", int'(busy), 0);
      check("exp_drained", exp_q.size(), 0);
      check("launch_drained", lq.size(), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, int'(bus.in_ready), 0);
      check({tag, "_out_valid"}, int'(bus.out_valid), 0);
      check({tag, "_out_pix"}, int'(bus.out_pix), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
   endtask

   task automatic load_identity(input int v);
      for (int k = 0; k < 25; k++) kc[k] = 0;
      kc[12] = 65535;
      for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = v;
   endtask

   initial begin
      int a0;
      reset = 1'b1;
      start = 1'b1;
      kernel_coef = '0;
      bus.in_valid = 1'b1;
      bus.in_pix = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      reset = 1'b0;
      start = 1'b0;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      check("no_start_under_reset", int'(busy), 0);

      // Identity kernel on a flat 200 frame.
      load_identity(200);
      run_frame(0, 1'b0, N);

      // Impulse through the sigma=1 kernel, with 1-0 valid toggling.
      for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) kc[i*5+j] = gauss_q(i, j);
      for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 0;
      img[10][10] = 255;
      run_frame(1, 1'b0, N);
      check("impulse_8_8", out_img[8][8], 41);
      check("impulse_6_6", out_img[6][6], 1);
      check("impulse_0_0", out_img[0][0], 0);
      check("impulse_11_11", out_img[11][11], 0);

      // Saturation: every coefficient full scale, constant 255 frame.
      for (int k = 0; k < 25; k++) kc[k] = 65535;
      for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 255;
      run_frame(0, 1'b0, N);
      check("sat_5_5", out_img[5][5], 255);

      // Ignored in_valid while idle.
      a0 = acc_n;
      bus.in_valid = 1'b1;
      bus.in_pix = 8'd77;
      repeat (10) @(posedge clk);
      #1;
      check("idle_no_accept", acc_n - a0, 0);
      check("idle_in_ready", int'(bus.in_ready), 0);
      check("idle_busy_hold", int'(busy), 0);
      bus.in_valid = 1'b0;

      // Reset after 100 pixels of a frame, then a clean identity frame.
      load_identity(90);
      run_frame(0, 1'b0, 100);
      reset = 1'b1;
      @(posedge clk); #1;
      exp_q.delete();
      lq.delete();
      check_reset_outputs("midreset");
      reset = 1'b0;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      load_identity(123);
      run_frame(2, 1'b1, N);

      // Random kernel and image, random gaps, start/kernel noise mid-frame.
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 25; k++) kc[k] = int'($urandom_range(0, 5000));
         for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) img[y][x] = int'($urandom_range(0, 255));
         run_frame(2, 1'b1, N);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
